// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter: FSM encoding and a
// ceiling-log2 helper used to size the grant index.
package fifo_arb_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_XFER = 1'b1
   } arb_state_t;

   // Ceiling log2, minimum 1 so a 2-requester grant index is still 1 bit wide.
   function automatic int clog2(input int value);
      int w;
      w = 1;
      while ((32'sd1 <<< w) < value) begin
         w = w + 32'sd1;
      end
      return w;
   endfunction

endpackage : fifo_arb_pkg

// File: rtl/fifo_arb_rr_pick.sv
// Round-robin picker: finds the first asserted request after last_id,
// wrapping from NUM_REQ-1 to 0. The request vector is duplicated, shifted so
// the search start lands on bit 0, and the lowest set bit is then encoded.
module fifo_arb_rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int IDW     = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDW-1:0]     last_id,
   output logic [IDW-1:0]     pick_id,
   output logic               pick_vld
);

   logic [IDW:0]           w_start;
   logic [IDW:0]           w_off;
   logic [IDW:0]           w_sum;
   logic [2*NUM_REQ-1:0]   w_rot;

   // Rotate the doubled request vector and priority-encode the lowest set bit.
   always_comb begin
      if ({1'b0, last_id} == (IDW+1)'(NUM_REQ - 1)) begin
         w_start = '0;
      end else begin
         w_start = {1'b0, last_id} + (IDW+1)'(1);
      end
      w_rot    = {req, req} >> w_start;
      pick_vld = 1'b0;
      w_off    = '0;
      // Scanning downward leaves the lowest set bit as the final winner.
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (w_rot[i]) begin
            pick_vld = 1'b1;
            w_off    = (IDW+1)'(i);
         end else begin
            pick_vld = pick_vld;
         end
      end
      w_sum = w_start + w_off;
      if (w_sum >= (IDW+1)'(NUM_REQ)) begin
         w_sum = w_sum - (IDW+1)'(NUM_REQ);
      end else begin
         w_sum = w_sum;
      end
      pick_id = w_sum[IDW-1:0];
   end

endmodule : fifo_arb_rr_pick

// File: rtl/fifo_wr_arbiter.sv
// Packet-aware round-robin arbiter for the single write port of the async
// FIFO. A grant is held until the granted source's last beat is written;
// fifo_wfull back-pressures the granted source combinationally.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int DSIZE   = 32,
   parameter int IDW     = clog2(NUM_REQ)
) (
   input  logic                     wclk,
   input  logic                     wrst_n,
   input  logic [NUM_REQ*DSIZE-1:0] s_data,
   input  logic [NUM_REQ-1:0]       s_valid,
   input  logic [NUM_REQ-1:0]       s_last,
   output logic [NUM_REQ-1:0]       s_ready,
   output logic [DSIZE-1:0]         fifo_wdata,
   output logic                     fifo_winc,
   input  logic                     fifo_wfull,
   output logic [IDW-1:0]           grant_id,
   output logic                     busy,
   output logic                     pkt_done
);

   arb_state_t          r_state;
   arb_state_t          w_state_nxt;
   logic [IDW-1:0]      r_grant_id;
   logic [IDW-1:0]      w_grant_nxt;
   logic                r_pkt_done;
   logic                w_pkt_done_nxt;
   logic [IDW-1:0]      w_pick_id;
   logic                w_pick_vld;
   logic [NUM_REQ-1:0]  w_ready;
   logic                w_winc;
   logic [DSIZE-1:0]    w_wdata;

   fifo_arb_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDW     (IDW)
   ) u_rr_pick (
      .req      (s_valid),
      .last_id  (r_grant_id),
      .pick_id  (w_pick_id),
      .pick_vld (w_pick_vld)
   );

   // State, grant index and done pulse; reset leaves requester 0 first in line.
   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         r_state    <= ST_IDLE;
         r_grant_id <= IDW'(NUM_REQ - 1);
         r_pkt_done <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_grant_id <= w_grant_nxt;
         r_pkt_done <= w_pkt_done_nxt;
      end
   end

   // Next-state decode plus the combinational write-port mux and handshake.
   always_comb begin
      w_state_nxt    = r_state;
      w_grant_nxt    = r_grant_id;
      w_pkt_done_nxt = 1'b0;
      w_ready        = '0;
      w_winc         = 1'b0;
      w_wdata        = '0;
      case (r_state)
         ST_IDLE: begin
            if (w_pick_vld) begin
               w_grant_nxt = w_pick_id;
               w_state_nxt = ST_XFER;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_XFER: begin
            w_ready[r_grant_id] = ~fifo_wfull;
            w_winc              = s_valid[r_grant_id] & ~fifo_wfull;
            w_wdata             = s_data[r_grant_id*DSIZE +: DSIZE];
            // The grant only ends once the last beat actually reaches the FIFO.
            if (w_winc && s_last[r_grant_id]) begin
               w_pkt_done_nxt = 1'b1;
               w_state_nxt    = ST_IDLE;
            end else begin
               w_state_nxt    = ST_XFER;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign s_ready    = w_ready;
   assign fifo_winc  = w_winc;
   assign fifo_wdata = w_wdata;
   assign grant_id   = r_grant_id;
   assign busy       = (r_state == ST_XFER);
   assign pkt_done   = r_pkt_done;

endmodule : fifo_wr_arbiter

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus a long
// randomized run, all checked cycle by cycle against a packet-level model.
module tb_fifo_wr_arbiter;

   localparam int N  = 4;
   localparam int DW = 32;

   logic              wclk;
   logic              wrst_n;
   logic [N*DW-1:0]   s_data;
   logic [N-1:0]      s_valid;
   logic [N-1:0]      s_last;
   logic [N-1:0]      s_ready;
   logic [DW-1:0]     fifo_wdata;
   logic              fifo_winc;
   logic              fifo_wfull;
   logic [1:0]        grant_id;
   logic              busy;
   logic              pkt_done;

   fifo_wr_arbiter #(.NUM_REQ(N), .DSIZE(DW), .IDW(2)) dut (
      .wclk       (wclk),
      .wrst_n     (wrst_n),
      .s_data     (s_data),
      .s_valid    (s_valid),
      .s_last     (s_last),
      .s_ready    (s_ready),
      .fifo_wdata (fifo_wdata),
      .fifo_winc  (fifo_winc),
      .fifo_wfull (fifo_wfull),
      .grant_id   (grant_id),
      .busy       (busy),
      .pkt_done   (pkt_done)
   );

   initial wclk = 1'b0;
   always #5 wclk = ~wclk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: who owns the write port (-1 = arbitrating), last grant.
   int m_owner;
   int m_gid;
   bit m_pd;

   // Source state: beats left in current packet, beat index, packets sent.
   int rem  [N];
   int beat [N];
   int pkts [N];

   int w_cnt;
   int pd_cnt;
   bit prev_busy;
   int grant_log[$];

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic clear_state();
      m_owner = -1;
      m_gid   = N - 1;
      m_pd    = 1'b0;
      for (int s = 0; s < N; s++) begin
         rem[s] = 0; beat[s] = 0; pkts[s] = 0;
      end
      w_cnt = 0; pd_cnt = 0; prev_busy = 1'b0;
      grant_log.delete();
   endtask

   // Hold reset with the given valids applied, check reset outputs, release.
   task automatic do_reset(input logic [N-1:0] vmask);
      @(negedge wclk);
      wrst_n     = 1'b0;
      s_valid    = vmask;
      s_last     = '0;
      fifo_wfull = 1'b0;
      repeat (2) @(negedge wclk);
      #1;
      check_eq("rst_ready", 32'(s_ready), 32'd0);
      check_eq("rst_winc",  32'(fifo_winc), 32'd0);
      check_eq("rst_gid",   32'(grant_id), 32'd3);
      check_eq("rst_busy",  32'(busy), 32'd0);
      check_eq("rst_pd",    32'(pkt_done), 32'd0);
      check_eq("rst_wdata", fifo_wdata, 32'd0);
      clear_state();
      s_valid = '0;
      wrst_n  = 1'b1;
   endtask

   // One cycle per iteration: drive at negedge, compare at +1, then advance
   // the model to what the next rising edge should produce.
   task automatic run(input int n, input logic [N-1:0] en, input int len,
                      input int p_valid, input int p_full,
                      input int full_lo, input int full_hi, input int max_pkts);
      logic [N-1:0]  e_ready;
      logic          e_winc;
      logic [DW-1:0] e_wdata;
      bit            found;
      int            idx;
      for (int c = 0; c < n; c++) begin
         @(negedge wclk);
         for (int s = 0; s < N; s++) begin
            if (en[s] && rem[s] == 0 && pkts[s] < max_pkts) begin
               rem[s] = (len > 0) ? len : int'($urandom_range(1, 4));
            end
            s_valid[s] = en[s] && rem[s] > 0 && ($urandom_range(0, 99) < p_valid);
            s_last[s]  = (rem[s] == 1);
            s_data[s*DW +: DW] = {8'(s), 12'(pkts[s]), 12'(beat[s])};
         end
         fifo_wfull = (c >= full_lo && c <= full_hi) || ($urandom_range(0, 99) < p_full);
         #1;
         e_ready = '0; e_winc = 1'b0; e_wdata = '0;
         if (m_owner >= 0) begin
            e_ready[m_owner] = ~fifo_wfull;
            e_winc           = s_valid[m_owner] & ~fifo_wfull;
            e_wdata          = s_data[m_owner*DW +: DW];
         end
         check_eq("ready", 32'(s_ready), 32'(e_ready));
         check_eq("winc",  32'(fifo_winc), 32'(e_winc));
         check_eq("wdata", fifo_wdata, e_wdata);
         check_eq("gid",   32'(grant_id), 32'(m_gid));
         check_eq("busy",  32'(busy), 32'(m_owner >= 0));
         check_eq("pdone", 32'(pkt_done), 32'(m_pd));
         if (busy && !prev_busy) grant_log.push_back(int'(grant_id));
         prev_busy = busy;
         w_cnt  += int'(fifo_winc);
         pd_cnt += int'(pkt_done);
         // Model update for the coming edge.
         m_pd = 1'b0;
         if (m_owner < 0) begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
               idx = (m_gid + k) % N;
               if (!found && s_valid[idx]) begin
                  found = 1'b1; m_gid = idx; m_owner = idx;
               end
            end
         end else if (e_winc && s_last[m_owner]) begin
            m_pd = 1'b1;
            m_owner = -1;
         end
         for (int s = 0; s < N; s++) begin
            if (e_ready[s] && s_valid[s]) begin
               rem[s]--; beat[s]++;
               if (rem[s] == 0) begin pkts[s]++; beat[s] = 0; end
            end
         end
      end
   endtask

   initial begin
      wrst_n = 1'b0; s_data = '0; s_valid = '0; s_last = '0; fifo_wfull = 1'b0;
      clear_state();

      // Reset with every source valid, then round-robin over 2-beat packets.
      do_reset(4'hF);
      run(16, 4'hF, 2, 100, 0, -1, -1, 1000);
      check_eq("rr_cnt", 32'(grant_log.size() >= 5), 32'd1);
      if (grant_log.size() >= 5) begin
         for (int i = 0; i < 5; i++) check_eq("rr_order", 32'(grant_log[i]), 32'(i % N));
      end
      check_eq("rr_writes", 32'(w_cnt), 32'd10);
      check_eq("rr_pdone",  32'(pd_cnt), 32'd5);

      // Source 2, 4 beats, FIFO full for cycles 2..5.
      do_reset(4'h0);
      run(12, 4'b0100, 4, 100, 0, 2, 5, 1);
      check_eq("bp_writes", 32'(w_cnt), 32'd4);
      check_eq("bp_pdone",  32'(pd_cnt), 32'd1);

      // Source 1 single-beat packet with last held against a full FIFO.
      do_reset(4'h0);
      run(8, 4'b0010, 1, 100, 0, 1, 3, 1);
      check_eq("lf_writes", 32'(w_cnt), 32'd1);
      check_eq("lf_pdone",  32'(pd_cnt), 32'd1);

      // Source 3 alone, back-to-back single-beat packets.
      do_reset(4'h0);
      run(20, 4'b1000, 1, 100, 0, -1, -1, 1000);
      check_eq("sr_writes", 32'(w_cnt), 32'd10);
      check_eq("sr_gid",    32'(grant_id), 32'd3);

      // Reset in the middle of a 5-beat packet from source 1.
      do_reset(4'h0);
      run(3, 4'b0010, 5, 100, 0, -1, -1, 1);
      @(negedge wclk);
      #1;
      check_eq("mr_busy_pre", 32'(busy), 32'd1);
      wrst_n = 1'b0;
      #1;
      check_eq("mr_busy",  32'(busy), 32'd0);
      check_eq("mr_ready", 32'(s_ready), 32'd0);
      check_eq("mr_winc",  32'(fifo_winc), 32'd0);
      check_eq("mr_gid",   32'(grant_id), 32'd3);
      @(negedge wclk);
      clear_state();
      s_valid = '0;
      wrst_n  = 1'b1;
      run(4, 4'b1100, 2, 100, 0, -1, -1, 1);
      check_eq("mr_next", 32'(grant_log.size() > 0 ? grant_log[0] : -1), 32'd2);

      // Long randomized run: random lengths, gaps, and full periods.
      do_reset(4'h0);
      run(3000, 4'hF, 0, 70, 25, -1, -1, 1000000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_fifo_wr_arbiter
